// File: rtl/des_region_scheduler.sv
// Purpose: sweeps one DES mask-counting block across a contiguous range of regions and sums its 48-bit ones-counters into a 64-bit total.
// Latency: go -> blk_restart 1 cycle, blk_start 2 cycles; blk_done -> accumulate next cycle, next region or result_valid 2 cycles after blk_done.
// Backpressure: none upstream; waits on blk_done level per region, optional watchdog aborts a region that never completes.
module des_region_scheduler #(
    parameter logic [15:0] REGION_FIRST = 16'h0000,
    parameter logic [16:0] REGION_COUNT = 17'd16,
    parameter logic [31:0] WATCHDOG     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        abort,
    input  logic        blk_done,
    input  logic [47:0] blk_counter,
    output logic        blk_start,
    output logic        blk_restart,
    output logic [15:0] blk_region_select,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic [16:0] regions_done,
    output logic [47:0] last_counter,
    output logic [63:0] total
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_ACCUM   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ABORT   = 3'd6;

    // Index of the final region and the watchdog count at which a region is given up.
    localparam logic [16:0] LAST_IDX = REGION_COUNT - 17'd1;
    localparam logic [31:0] WD_LAST  = WATCHDOG - 32'd1;

    logic [2:0]  state;
    logic [16:0] idx;
    logic [31:0] wd_cnt;
    logic        launch;

    // A new sweep starts from IDLE (abort has priority there) or from DONE (abort is ignored there).
    always_comb begin
        launch = 1'b0;
        if (state == S_IDLE) begin
            launch = go && !abort;
        end else if (state == S_DONE) begin
            launch = go;
        end
    end

    // Sweep sequencing, watchdog and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            idx               <= 17'd0;
            wd_cnt            <= 32'd0;
            blk_region_select <= REGION_FIRST;
            timeout           <= 1'b0;
            regions_done      <= 17'd0;
            last_counter      <= 48'd0;
            total             <= 64'd0;
        end else if (launch) begin
            state             <= S_RESTART;
            idx               <= 17'd0;
            blk_region_select <= REGION_FIRST;
            timeout           <= 1'b0;
            regions_done      <= 17'd0;
            last_counter      <= 48'd0;
            total             <= 64'd0;
        end else begin
            case (state)
                S_RESTART: begin
                    state <= abort ? S_ABORT : S_START;
                end
                S_START: begin
                    wd_cnt <= 32'd0;
                    state  <= abort ? S_ABORT : S_WAIT;
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_ABORT;
                    end else if (blk_done) begin
                        state <= S_ACCUM;
                    end else if ((WATCHDOG != 32'd0) && (wd_cnt == WD_LAST)) begin
                        state   <= S_ABORT;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                S_ACCUM: begin
                    // An abort here discards this region's counter entirely.
                    if (abort) begin
                        state <= S_ABORT;
                    end else begin
                        total        <= total + {16'd0, blk_counter};
                        last_counter <= blk_counter;
                        regions_done <= regions_done + 17'd1;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx               <= idx + 17'd1;
                            // Region numbers wrap modulo 2^16.
                            blk_region_select <= REGION_FIRST + idx[15:0] + 16'd1;
                            state             <= S_RESTART;
                        end
                    end
                end
                S_ABORT: begin
                    state <= S_IDLE;
                end
                S_IDLE, S_DONE: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore-decoded handshake and status outputs.
    always_comb begin
        blk_restart  = (state == S_RESTART) || (state == S_ABORT);
        blk_start    = (state == S_START);
        result_valid = (state == S_DONE);
        busy         = (state == S_RESTART) || (state == S_START) || (state == S_WAIT) ||
                       (state == S_ACCUM)   || (state == S_ABORT);
    end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Purpose: randomized sweeps of des_region_scheduler against a cycle-level reference schedule, with a behavioural DES block.
// Latency: expected events carry absolute cycle stamps derived from go, start and done timing.
// Backpressure: the block model holds blk_done off for a chosen delay, or forever to provoke the watchdog.
module tb_des_region_scheduler;

    localparam logic [15:0] RFIRST = 16'hFFFE;
    localparam int          RCOUNT = 4;
    localparam int          WD     = 20;

    logic        clk;
    logic        rst;
    logic        go;
    logic        abort;
    logic        blk_done;
    logic [47:0] blk_counter;
    logic        blk_start;
    logic        blk_restart;
    logic [15:0] blk_region_select;
    logic        busy;
    logic        result_valid;
    logic        timeout;
    logic [16:0] regions_done;
    logic [47:0] last_counter;
    logic [63:0] total;

    des_region_scheduler #(
        .REGION_FIRST(RFIRST),
        .REGION_COUNT(17'(RCOUNT)),
        .WATCHDOG(32'(WD))
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .abort(abort),
        .blk_done(blk_done),
        .blk_counter(blk_counter),
        .blk_start(blk_start),
        .blk_restart(blk_restart),
        .blk_region_select(blk_region_select),
        .busy(busy),
        .result_valid(result_valid),
        .timeout(timeout),
        .regions_done(regions_done),
        .last_counter(last_counter),
        .total(total)
    );

    typedef struct {
        int          kind;   // 0 restart pulse, 1 start pulse, 2 sweep end (busy falls)
        int          cyc;
        logic [15:0] sel;
        logic [63:0] tot;
        logic [16:0] rd;
        logic [47:0] last;
        logic        to;
        logic        rv;
    } ev_t;

    ev_t q[$];
    ev_t exp_local[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [47:0] cnt_tab [RCOUNT];
    int          dly_tab [RCOUNT];
    int          abort_reg;
    int          abort_off;
    int          abort_cyc;
    int          blk_k;
    logic        exp_rv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp, advanced on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int kind, input int c, input logic [15:0] sel,
                               input logic [63:0] tot, input logic [16:0] rd,
                               input logic [47:0] last, input logic to, input logic rv);
        ev_t e;
        e.kind = kind; e.cyc = c; e.sel = sel; e.tot = tot;
        e.rd = rd; e.last = last; e.to = to; e.rv = rv;
        return e;
    endfunction

    // Reference schedule: restart/start per region, done d cycles after start,
    // next region two cycles after done; aborts and watchdog end the sweep early.
    task automatic build_model(input int g);
        int          t;
        int          s;
        logic [63:0] tot;
        logic [16:0] rd;
        logic [47:0] last;
        logic [15:0] sel;
        bit          ended;
        exp_local.delete();
        t = g + 1; tot = 0; rd = 0; last = 0; sel = RFIRST; ended = 0; abort_cyc = -1;
        for (int i = 0; i < RCOUNT && !ended; i++) begin
            sel = 16'(RFIRST + 16'(i));
            s = t + 1;
            exp_local.push_back(mk(0, t, sel, 0, 0, 0, 0, 0));
            exp_local.push_back(mk(1, s, sel, 0, 0, 0, 0, 0));
            if (abort_reg == i) begin
                abort_cyc = s + abort_off;
                exp_local.push_back(mk(0, s + abort_off + 1, sel, 0, 0, 0, 0, 0));
                exp_local.push_back(mk(2, s + abort_off + 2, sel, tot, rd, last, 1'b0, 1'b0));
                ended = 1;
            end else if (dly_tab[i] == 0) begin
                exp_local.push_back(mk(0, s + 1 + WD, sel, 0, 0, 0, 0, 0));
                exp_local.push_back(mk(2, s + 2 + WD, sel, tot, rd, last, 1'b1, 1'b0));
                ended = 1;
            end else begin
                tot  = tot + 64'(cnt_tab[i]);
                rd   = rd + 1;
                last = cnt_tab[i];
                t    = s + dly_tab[i] + 2;
            end
        end
        if (!ended) exp_local.push_back(mk(2, t, sel, tot, rd, last, 1'b0, 1'b1));
    endtask

    // Behavioural DES block: raises done a programmed delay after start, cleared by restart.
    initial begin
        bit          pending;
        int          target;
        logic [47:0] val;
        logic [63:0] junk;
        pending = 0; target = 0; val = 0;
        blk_done = 1'b0; blk_counter = 48'd0;
        forever begin
            @(posedge clk); #1;
            if (blk_restart === 1'b1) begin
                blk_done = 1'b0;
                pending  = 0;
            end
            if (blk_start === 1'b1 && blk_k < RCOUNT) begin
                if (dly_tab[blk_k] != 0) begin
                    pending = 1;
                    target  = cyc + dly_tab[blk_k];
                    val     = cnt_tab[blk_k];
                end
                blk_k++;
            end
            if (pending && cyc == target) begin
                blk_done    = 1'b1;
                blk_counter = val;
                pending     = 0;
            end
            if (!blk_done) begin
                junk        = {$urandom, $urandom};
                blk_counter = junk[47:0];
            end
        end
    end

    // Monitor: every restart/start pulse and every busy fall is matched against the scoreboard.
    bit   prev_busy = 0;
    bit   mon_seen;
    int   mon_k;
    ev_t  mon_e;
    always @(negedge clk) begin
        mon_seen = 0;
        mon_k    = 0;
        if (blk_restart === 1'b1) begin
            mon_seen = 1; mon_k = 0;
        end else if (blk_start === 1'b1) begin
            mon_seen = 1; mon_k = 1;
        end else if (prev_busy && busy === 1'b0) begin
            mon_seen = 1; mon_k = 2;
        end
        prev_busy = (busy === 1'b1);
        if (mon_seen) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", mon_k, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind", 64'(mon_k), 64'(mon_e.kind));
                chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("region_select", 64'(blk_region_select), 64'(mon_e.sel));
                if (mon_e.kind == 2) begin
                    chk("total", total, mon_e.tot);
                    chk("regions_done", 64'(regions_done), 64'(mon_e.rd));
                    chk("last_counter", 64'(last_counter), 64'(mon_e.last));
                    chk("timeout", 64'(timeout), 64'(mon_e.to));
                    chk("result_valid", 64'(result_valid), 64'(mon_e.rv));
                end
            end
        end
    end

    // Drive one sweep; rst_off >= 0 asserts reset that many cycles after go.
    task automatic run_sweep(input bit go_busy, input int rst_off);
        int g;
        int endc;
        int rc;
        @(posedge clk); #1;
        g = cyc;
        build_model(g);
        rc = -1;
        if (rst_off >= 0) begin
            rc = g + rst_off;
            while (exp_local.size() > 0 && exp_local[$].cyc > rc) void'(exp_local.pop_back());
            exp_local.push_back(mk(2, rc + 1, RFIRST, 0, 0, 0, 1'b0, 1'b0));
        end
        endc   = exp_local[$].cyc;
        exp_rv = exp_local[$].rv;
        foreach (exp_local[i]) q.push_back(exp_local[i]);
        blk_k = 0;
        while (cyc <= endc) begin
            go    = (cyc == g) || (go_busy && cyc == g + 3);
            abort = (cyc == abort_cyc);
            rst   = (cyc == rc);
            @(posedge clk); #1;
        end
        go = 1'b0; abort = 1'b0; rst = 1'b0;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Pulses that must be ignored: go+abort while idle, abort alone while idle or done.
    task automatic idle_noise();
        @(posedge clk); #1;
        abort = 1'b1;
        go    = !exp_rv;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_result_valid_hold", 64'(result_valid), 64'(exp_rv));
        chk("idle_not_busy", 64'(busy), 64'd0);
    endtask

    task automatic random_plan();
        logic [63:0] r;
        bit          ones;
        int          d;
        ones = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < RCOUNT; i++) begin
            r          = {$urandom, $urandom};
            cnt_tab[i] = ones ? 48'hFFFF_FFFF_FFFF : r[47:0];
            dly_tab[i] = $urandom_range(1, 12);
        end
        abort_reg = -1;
        abort_off = 0;
        if ($urandom_range(0, 5) == 0) begin
            dly_tab[$urandom_range(0, RCOUNT - 1)] = 0;
        end else if ($urandom_range(0, 4) == 0) begin
            abort_reg = $urandom_range(0, RCOUNT - 1);
            d = dly_tab[abort_reg];
            case ($urandom_range(0, 2))
                0: abort_off = 0;
                1: abort_off = (d > 1) ? $urandom_range(1, d - 1) : d + 1;
                default: abort_off = d + 1;
            endcase
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: run exceeded 400000 ns");
        $fatal(1, "simulation limit reached");
    end

    initial begin
        rst = 1'b1; go = 1'b0; abort = 1'b0; blk_k = 0; exp_rv = 1'b0;
        abort_reg = -1; abort_off = 0; abort_cyc = -1;
        for (int i = 0; i < RCOUNT; i++) begin
            cnt_tab[i] = 48'd0;
            dly_tab[i] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result_valid", 64'(result_valid), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        chk("reset_blk_start", 64'(blk_start), 64'd0);
        chk("reset_blk_restart", 64'(blk_restart), 64'd0);
        chk("reset_regions_done", 64'(regions_done), 64'd0);
        chk("reset_last_counter", 64'(last_counter), 64'd0);
        chk("reset_total", total, 64'd0);
        chk("reset_select", 64'(blk_region_select), 64'(RFIRST));

        // Small known counters, done 10 cycles after each start, selects wrap FFFE..0001.
        cnt_tab[0] = 48'd5; cnt_tab[1] = 48'd7; cnt_tab[2] = 48'd11; cnt_tab[3] = 48'd13;
        for (int i = 0; i < RCOUNT; i++) dly_tab[i] = 10;
        run_sweep(1'b0, -1);
        chk("directed_total_36", total, 64'd36);
        idle_noise();

        // All-ones counters: no truncation of the 64-bit sum.
        for (int i = 0; i < RCOUNT; i++) begin
            cnt_tab[i] = 48'hFFFF_FFFF_FFFF;
            dly_tab[i] = $urandom_range(1, 12);
        end
        run_sweep(1'b0, -1);
        chk("all_ones_total", total, 64'h3_FFFF_FFFF_FFFC);

        // Block never answers: watchdog ends the sweep.
        dly_tab[0] = 0;
        run_sweep(1'b0, -1);
        idle_noise();

        // Abort in WAIT of region 1 after region 0 returned 9.
        cnt_tab[0] = 48'd9; cnt_tab[1] = 48'd100; cnt_tab[2] = 48'd3; cnt_tab[3] = 48'd4;
        for (int i = 0; i < RCOUNT; i++) dly_tab[i] = 10;
        abort_reg = 1; abort_off = 3;
        run_sweep(1'b0, -1);
        abort_reg = -1;
        run_sweep(1'b1, -1);

        for (int n = 0; n < 25; n++) begin
            random_plan();
            run_sweep(($urandom_range(0, 2) == 0), -1);
            if ($urandom_range(0, 2) == 0) idle_noise();
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        // Reset mid-WAIT of region 1 with a go pulsed while busy; nothing may follow.
        for (int i = 0; i < RCOUNT; i++) cnt_tab[i] = 48'd50 + 48'(i);
        dly_tab[0] = 5; dly_tab[1] = 10; dly_tab[2] = 3; dly_tab[3] = 3;
        abort_reg = -1;
        run_sweep(1'b1, 13);
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_total", total, 64'd0);

        random_plan();
        run_sweep(1'b0, -1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_region_scheduler.md
Name: des_region_scheduler

Overview:
- Sweeps one DES mask-counting block through a contiguous range of message regions, one region at a time.
- Per region: restarts the block, programs region_select, pulses start, waits for done, then adds the block's 48-bit ones-counter into a 64-bit running total.
- Sits between the CPU register interface and the DES block. Upstream of the block it drives start/restart_block/region_select; downstream of it, it consumes done/counter.

Parameters:
- REGION_FIRST, 16'h0000, region index of the first region in the sweep.
- REGION_COUNT, 17'd16, number of regions to sweep; legal range 1..65536.
- WATCHDOG, 32'd0, maximum cycles to wait for blk_done per region; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- go  in  1  one-cycle pulse from CPU; starts a sweep
- abort  in  1  one-cycle pulse; cancels a running sweep
- blk_done  in  1  done from DES block, level
- blk_counter  in  48  ones-counter from DES block, valid while blk_done=1
- blk_start  out  1  start to DES block
- blk_restart  out  1  restart_block to DES block
- blk_region_select  out  16  region_select to DES block
- busy  out  1  sweep in progress
- result_valid  out  1  total is final for the completed sweep
- timeout  out  1  sticky; watchdog expired during the last sweep
- regions_done  out  17  number of regions accumulated in the current/last sweep
- last_counter  out  48  blk_counter captured for the most recent region
- total  out  64  sum of captured counters

Behaviour:
- All outputs are registered or Moore-decoded from state. No combinational input-to-output paths.
- Reset (rst=1 at a clock edge, any state):
  - state IDLE.
  - busy, result_valid, timeout, blk_start, blk_restart = 0.
  - regions_done, last_counter, total = 0.
  - blk_region_select = REGION_FIRST; internal idx = 0; watchdog count = 0.
- States: IDLE, RESTART, START, WAIT, ACCUM, DONE, ABORT.
- IDLE:
  - busy=0.
  - go=1 and abort=0 -> RESTART. On the same edge: clear total, regions_done, last_counter, timeout, result_valid; set idx=0.
  - go and abort in the same cycle: abort wins, stay IDLE.
- RESTART:
  - blk_restart=1 for exactly this one cycle.
  - blk_region_select = REGION_FIRST+idx, mod 2^16 (wraps past 16'hFFFF).
  - -> START.
- START: blk_start=1 for exactly one cycle; watchdog count cleared; -> WAIT.
- WAIT:
  - blk_done=1 -> ACCUM.
  - Else, if WATCHDOG!=0 and count==WATCHDOG-1 -> ABORT with timeout<=1.
  - Else count++.
- ACCUM (one cycle):
  - total <= total + zero-extended blk_counter. 64 bits cannot overflow for REGION_COUNT<=65536.
  - last_counter <= blk_counter; regions_done++.
  - If idx==REGION_COUNT-1 -> DONE. Else idx++ and -> RESTART.
- DONE:
  - busy=0, result_valid=1. Outputs hold.
  - go -> RESTART, same actions as from IDLE.
  - abort ignored.
- ABORT:
  - blk_restart=1 for one cycle, result_valid=0 -> IDLE.
  - total, regions_done and last_counter keep their partial values; timeout keeps its value.
- busy=1 in RESTART, START, WAIT, ACCUM and ABORT.
- abort=1 in RESTART, START, WAIT or ACCUM -> ABORT on the next edge. An ACCUM interrupted this way does not update the accumulators.
- go while busy=1 is ignored.
- Timing from go in cycle 0:
  - blk_restart high in cycle 1.
  - blk_start high in cycle 2.
  - WAIT from cycle 3.
- Timing from blk_done first high in cycle n:
  - ACCUM in cycle n+1.
  - Updated total visible in cycle n+2.
  - Next blk_restart in cycle n+2, or result_valid in cycle n+2 for the last region.
- blk_region_select changes only on entry to RESTART and is stable through START and WAIT.

Test Plan:
- REGION_FIRST=0, REGION_COUNT=3, model returns counters 5, 7, 11, with done 10 cycles after each start:
  - expect select sequence 0, 1, 2, each with a 1-cycle restart followed by a 1-cycle start;
  - expect total=23, regions_done=3, last_counter=11, result_valid=1, busy=0.
- REGION_FIRST=16'hFFFF, REGION_COUNT=2 -> selects 16'hFFFF then 16'h0000 (wrap); sweep completes normally.
- Model returns 48'hFFFF_FFFF_FFFF for 4 regions -> total=64'h3_FFFF_FFFF_FFFC with no truncation.
- WATCHDOG=20, model never asserts done:
  - blk_restart pulses exactly 20 cycles after WAIT entry;
  - timeout=1, result_valid=0, state IDLE, regions_done=0.
- abort during WAIT of region 1, with region 0 counter=9:
  - next cycle blk_restart=1, then IDLE;
  - total=9, regions_done=1;
  - a subsequent go clears total to 0 and restarts at REGION_FIRST.
- rst=1 mid-WAIT and go pulsed while busy:
  - busy go ignored, select unchanged;
  - after rst all outputs equal their reset values, and no blk_start appears until a new go.
